fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch controller that sequences the program counter and instruction-memory accesses for the IF stage of the rv32 core. It issues word fetches over a req/ack handshake to instruction memory (variable latency, zero-wait allowed), buffers returned instructions with their PCs in a small prefetch queue, and handles branch redirects (PCsrc) by flushing queued and in-flight fetches. Sits between the branch-resolution logic, `ins_mem`, and the decode stage.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; must be word aligned.
- `BUF_DEPTH`, default 2: prefetch queue entries; power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `redirect_valid` in 1: branch/jump taken this cycle (PCsrc).
- `redirect_addr` in 32: redirect target (branch_addr).
- `mem_req` out 1: fetch request to instruction memory.
- `mem_addr` out 32: byte address of the fetched word, always [1:0]=0.
- `mem_ack` in 1: memory returns `mem_rdata` this cycle; meaningful only while `mem_req`=1.
- `mem_rdata` in 32: fetched instruction word.
- `if_valid` out 1: queue head holds a valid instruction.
- `if_instr` out 32: head instruction.
- `if_pc` out 32: head instruction's PC.
- `if_ready` in 1: decode accepts head this cycle.
- `misalign` out 1: one-cycle pulse when a redirect target had [1:0]≠0.

## Operation
- Internal `fetch_pc` (next address to request) and FSM {IDLE, REQ, FLUSH}; at most one request outstanding.
- Space rule: new request issued only if (queue count after this cycle's push/pop) < BUF_DEPTH.
- IDLE: `mem_req`=0; go REQ when space exists.
- REQ: `mem_req`=1, `mem_addr`=`fetch_pc`, held stable until `mem_ack`. On ack: push {fetch_pc, mem_rdata}, fetch_pc += 4 (mod 2^32, wrap to 0); stay REQ if space remains, else IDLE.
- FLUSH: `mem_req`=1 held on stale address until `mem_ack`; returned data discarded; then REQ at `fetch_pc`.
- Redirect (highest priority): queue cleared; `fetch_pc` ← {redirect_addr[31:2], 2'b00}; `misalign` pulses next cycle if redirect_addr[1:0]≠0.
  - From IDLE → REQ. From REQ without ack → FLUSH. From REQ with ack same cycle → ack data discarded, → REQ at new address. From FLUSH without ack → stay FLUSH with updated target; with ack → REQ.
- Redirect and `if_valid && if_ready` in same cycle: the pop completes (head counted as consumed), all remaining entries flushed.
- Push and pop in same cycle with full queue: legal, count unchanged.
- `if_valid`=0 when queue empty; `if_instr`/`if_pc` hold last value (don't care) when invalid.

## Timing
- Reset (rst_n=0 at clk edge): state IDLE, `fetch_pc`=RESET_PC, queue empty, `mem_req`=0, `mem_addr`=RESET_PC, `if_valid`=0, `if_instr`=0, `if_pc`=0, `misalign`=0. Reset mid-request abandons it; memory must tolerate dropped req.
- First `mem_req` asserted the first cycle after `rst_n` samples high.
- Ack in cycle N → `if_valid`=1 in cycle N+1 with that word.
- Zero-wait memory, `if_ready`=1 constantly: one instruction per cycle steady state, `mem_req` continuously high.
- Redirect in cycle N → `if_valid`=0 in N+1; new-target request visible on `mem_addr` in N+1 (unless FLUSH); first target instruction valid ≥ N+2.
- All outputs registered or driven from registers only; no combinational path mem_ack→mem_req.

## Structure
- Package `fetch_pkg`: `fetch_state_e` enum {IDLE, REQ, FLUSH}; `fetch_entry_t` struct {pc[31:0], instr[31:0]}; constant `INSTR_BYTES`=4.
- Sub-module `fetch_buf`: synchronous FIFO of `fetch_entry_t`, depth BUF_DEPTH, push/pop/flush, count output, flush dominant over push.

## Test plan
- Reset release, zero-wait memory returning addr as data, if_ready=1 → pcs 0,4,8,12 on consecutive cycles, if_instr==if_pc.
- if_ready=0 for 5 cycles → exactly 2 entries queued, `mem_req` drops, `mem_addr`=8; release → 0,4,8 in order, no gaps or duplicates.
- Memory with 3-cycle ack latency, redirect to 0x100 in 2nd wait cycle → stale word for old pc discarded, next valid if_pc=0x100.
- Redirect to 0x203 same cycle as ack and pop → popped head consumed, ack data dropped, `misalign` pulses once, next if_pc=0x200.
- fetch_pc=0xFFFF_FFFC → following request at 0x0000_0000.
- rst_n low during outstanding request → all outputs at reset values next cycle, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the IF-stage fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0]  INSTR_BYTES = 32'd4;
    localparam fetch_entry_t ENTRY_ZERO  = '{pc: 32'h0000_0000, instr: 32'h0000_0000};

    // Force a byte address onto its containing word.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // True when a byte address does not sit on a word boundary.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the fetch controller's redirect, instruction-memory and decode-side signals.
interface fetch_ctrl_if;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        misalign;

    // Controller view.
    modport master (
        input  redirect_valid, redirect_addr, mem_ack, mem_rdata, if_ready,
        output mem_req, mem_addr, if_valid, if_instr, if_pc, misalign
    );

    // Environment view (branch unit, instruction memory, decode).
    modport slave (
        output redirect_valid, redirect_addr, mem_ack, mem_rdata, if_ready,
        input  mem_req, mem_addr, if_valid, if_instr, if_pc, misalign
    );
endinterface

// File: rtl/fetch_buf.sv
// Prefetch queue: small synchronous FIFO of {pc, instr} entries with flush.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  wr_data,
    output fetch_entry_t  head,
    output logic [CW-1:0] count,
    output logic          empty
);
    localparam int unsigned PW = $clog2(DEPTH);

    fetch_entry_t  mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_pop_s;
    logic          do_push_s;

    // Qualify requests: never pop an empty queue, never overwrite a full one unless it also drains.
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        do_pop_s  = pop && (count_r != {CW{1'b0}});
        do_push_s = push && !flush && ((count_r < CW'(DEPTH)) || do_pop_s);
    end

    // Storage, pointers and occupancy; flush dominates so a flushed cycle's push is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= ENTRY_ZERO;
            end
        end else if (flush) begin
            rd_ptr_r <= wr_ptr_r;
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            if (do_push_s && !do_pop_s) begin
                count_r <= count_r + CW'(1'b1);
            end else if (!do_push_s && do_pop_s) begin
                count_r <= count_r - CW'(1'b1);
            end else begin
                count_r <= count_r;
            end
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage fetch controller: sequences the PC, issues one outstanding word fetch at a
// time, queues returned instructions and flushes on branch redirects.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_ctrl_if.master bus
);
    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e  state_r;
    fetch_state_e  state_next_s;
    logic [31:0]   fetch_pc_r;
    logic [31:0]   fetch_pc_next_s;
    logic          mem_req_r;
    logic [31:0]   mem_addr_r;
    logic [31:0]   mem_addr_next_s;
    logic          misalign_r;
    logic [31:0]   target_s;
    logic          push_s;
    logic          pop_s;
    logic          space_s;
    logic [CW-1:0] count_s;
    logic [CW-1:0] count_next_s;
    logic          empty_s;
    fetch_entry_t  head_s;
    fetch_entry_t  wr_entry_s;

    assign target_s   = word_align(bus.redirect_addr);
    assign pop_s      = !empty_s && bus.if_ready;
    assign push_s     = (state_r == REQ) && bus.mem_ack;
    assign wr_entry_s = '{pc: fetch_pc_r, instr: bus.mem_rdata};

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_s),
        .pop     (pop_s),
        .flush   (bus.redirect_valid),
        .wr_data (wr_entry_s),
        .head    (head_s),
        .count   (count_s),
        .empty   (empty_s)
    );

    // Project queue occupancy after this cycle's push/pop/flush to decide if another fetch fits.
    always_comb begin
        count_next_s = count_s;
        space_s      = 1'b0;
        if (bus.redirect_valid) begin
            count_next_s = {CW{1'b0}};
        end else if (push_s && !pop_s) begin
            count_next_s = count_s + CW'(1'b1);
        end else if (!push_s && pop_s) begin
            count_next_s = count_s - CW'(1'b1);
        end else begin
            count_next_s = count_s;
        end
        space_s = (count_next_s < CW'(BUF_DEPTH));
    end

    // Next-state, next fetch address and next request address; redirect has top priority.
    always_comb begin
        state_next_s    = state_r;
        fetch_pc_next_s = fetch_pc_r;
        mem_addr_next_s = mem_addr_r;
        case (state_r)
            IDLE: begin
                if (bus.redirect_valid) begin
                    state_next_s    = REQ;
                    fetch_pc_next_s = target_s;
                end else if (space_s) begin
                    state_next_s = REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                if (bus.redirect_valid) begin
                    fetch_pc_next_s = target_s;
                    // Without an ack the stale request must still be retired.
                    if (bus.mem_ack) begin
                        state_next_s = REQ;
                    end else begin
                        state_next_s = FLUSH;
                    end
                end else if (bus.mem_ack) begin
                    fetch_pc_next_s = fetch_pc_r + INSTR_BYTES;
                    if (space_s) begin
                        state_next_s = REQ;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = REQ;
                end
            end
            FLUSH: begin
                if (bus.redirect_valid) begin
                    fetch_pc_next_s = target_s;
                end else begin
                    fetch_pc_next_s = fetch_pc_r;
                end
                if (bus.mem_ack) begin
                    state_next_s = REQ;
                end else begin
                    state_next_s = FLUSH;
                end
            end
            default: begin
                state_next_s    = IDLE;
                fetch_pc_next_s = fetch_pc_r;
            end
        endcase
        // The stale address stays on the bus while a flushed request is still pending.
        if (state_next_s == FLUSH) begin
            mem_addr_next_s = mem_addr_r;
        end else begin
            mem_addr_next_s = fetch_pc_next_s;
        end
    end

    // State, PC and registered memory-side outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            mem_req_r  <= 1'b0;
            mem_addr_r <= RESET_PC;
            misalign_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            fetch_pc_r <= fetch_pc_next_s;
            mem_req_r  <= (state_next_s != IDLE);
            mem_addr_r <= mem_addr_next_s;
            misalign_r <= bus.redirect_valid && is_misaligned(bus.redirect_addr);
        end
    end

    assign bus.mem_req  = mem_req_r;
    assign bus.mem_addr = mem_addr_r;
    assign bus.misalign = misalign_r;
    assign bus.if_valid = !empty_s;
    assign bus.if_instr = head_s.instr;
    assign bus.if_pc    = head_s.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a latency-configurable memory model plus a
// stream-level scoreboard (decode must see consecutive PCs, restarting at each redirect target).
module tb_fetch_ctrl;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fetch_ctrl_if bus();

    fetch_ctrl #(
        .RESET_PC  (TB_RESET_PC),
        .BUF_DEPTH (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_pops   = 0;
    logic [31:0] exp_pc   = TB_RESET_PC;
    logic [31:0] key      = 32'h0000_0000;
    int unsigned wait_cnt = 0;
    int unsigned cur_lat  = 0;
    int unsigned lat_min  = 0;
    int unsigned lat_max  = 0;
    bit          have_prev = 1'b0;
    bit          prev_redir, prev_mis, prev_pend;
    logic [31:0] prev_target, prev_addr;

    // One clock cycle, entered and left at a falling edge: memory responds, scoreboard checks.
    task automatic tick();
        bit req_now, ack_now, pop_now;
        req_now = (bus.mem_req === 1'b1);
        if (req_now && wait_cnt >= cur_lat) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = bus.mem_addr ^ key;
        end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom();
        end
        ack_now = req_now && (bus.mem_ack === 1'b1);
        if (have_prev) begin
            if (prev_redir) begin
                n_checks++;
                if (bus.if_valid !== 1'b0) $display("FAIL sb_redirect_empty: if_valid=%b, want 0", bus.if_valid);
                else n_pass++;
                n_checks++;
                if (bus.misalign !== prev_mis) $display("FAIL sb_misalign: misalign=%b, want %b", bus.misalign, prev_mis);
                else n_pass++;
                if (!prev_pend) begin
                    n_checks++;
                    if (bus.mem_req !== 1'b1 || bus.mem_addr !== prev_target)
                        $display("FAIL sb_redirect_req: req=%b addr=%h, want 1 %h", bus.mem_req, bus.mem_addr, prev_target);
                    else n_pass++;
                end
            end else begin
                n_checks++;
                if (bus.misalign !== 1'b0) $display("FAIL sb_misalign_idle: misalign=%b, want 0", bus.misalign);
                else n_pass++;
            end
            if (prev_pend) begin
                n_checks++;
                if (bus.mem_req !== 1'b1 || bus.mem_addr !== prev_addr)
                    $display("FAIL sb_req_hold: req=%b addr=%h, want 1 %h", bus.mem_req, bus.mem_addr, prev_addr);
                else n_pass++;
            end
        end
        if (req_now) begin
            n_checks++;
            if (bus.mem_addr[1:0] !== 2'b00) $display("FAIL sb_addr_align: addr=%h, want word aligned", bus.mem_addr);
            else n_pass++;
        end
        pop_now = (rst_n === 1'b1) && (bus.if_valid === 1'b1) && (bus.if_ready === 1'b1);
        if (pop_now) begin
            n_checks++;
            if (bus.if_pc !== exp_pc || bus.if_instr !== (exp_pc ^ key))
                $display("FAIL sb_pop: pc=%h instr=%h, want pc=%h instr=%h", bus.if_pc, bus.if_instr, exp_pc, exp_pc ^ key);
            else n_pass++;
            exp_pc = exp_pc + 32'd4;
            n_pops++;
        end
        if (rst_n === 1'b1 && bus.redirect_valid === 1'b1) exp_pc = {bus.redirect_addr[31:2], 2'b00};
        have_prev   = (rst_n === 1'b1);
        prev_redir  = (bus.redirect_valid === 1'b1);
        prev_mis    = (bus.redirect_addr[1:0] != 2'b00);
        prev_target = {bus.redirect_addr[31:2], 2'b00};
        prev_pend   = req_now && !ack_now;
        prev_addr   = bus.mem_addr;
        @(posedge clk);
        if (rst_n !== 1'b1) begin
            exp_pc   = TB_RESET_PC;
            wait_cnt = 0;
            cur_lat  = $urandom_range(lat_max, lat_min);
        end else if (ack_now) begin
            wait_cnt = 0;
            cur_lat  = $urandom_range(lat_max, lat_min);
        end else if (req_now) begin
            wait_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 32'h0000_0000;
        bus.if_ready       = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        lat_min = 0; lat_max = 0; key = 32'h0000_0000;
        do_reset();
        n_checks++; if (bus.mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b, want 0", bus.mem_req); else n_pass++;
        n_checks++; if (bus.mem_addr !== TB_RESET_PC) $display("FAIL rst_mem_addr: got %h, want %h", bus.mem_addr, TB_RESET_PC); else n_pass++;
        n_checks++; if (bus.if_valid !== 1'b0) $display("FAIL rst_if_valid: got %b, want 0", bus.if_valid); else n_pass++;
        n_checks++; if (bus.if_instr !== 32'h0) $display("FAIL rst_if_instr: got %h, want 0", bus.if_instr); else n_pass++;
        n_checks++; if (bus.if_pc !== 32'h0) $display("FAIL rst_if_pc: got %h, want 0", bus.if_pc); else n_pass++;
        n_checks++; if (bus.misalign !== 1'b0) $display("FAIL rst_misalign: got %b, want 0", bus.misalign); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== TB_RESET_PC)
            $display("FAIL first_req: req=%b addr=%h, want 1 %h", bus.mem_req, bus.mem_addr, TB_RESET_PC);
        else n_pass++;
    endtask

    task automatic test_zero_wait();
        lat_min = 0; lat_max = 0; key = 32'h0000_0000;
        do_reset();
        bus.if_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(4 * i) || bus.if_instr !== 32'(4 * i) || bus.mem_req !== 1'b1)
                $display("FAIL zero_wait[%0d]: valid=%b pc=%h instr=%h req=%b, want 1 %h %h 1",
                         i, bus.if_valid, bus.if_pc, bus.if_instr, bus.mem_req, 32'(4 * i), 32'(4 * i));
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_backpressure();
        lat_min = 0; lat_max = 0; key = 32'h1357_9BDF;
        do_reset();
        rst_n = 1'b1;
        repeat (5) tick();
        n_checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0000_0008 || bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0)
            $display("FAIL bp_stall: req=%b addr=%h valid=%b pc=%h, want 0 00000008 1 00000000",
                     bus.mem_req, bus.mem_addr, bus.if_valid, bus.if_pc);
        else n_pass++;
        bus.if_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(4 * i))
                $display("FAIL bp_drain[%0d]: valid=%b pc=%h, want 1 %h", i, bus.if_valid, bus.if_pc, 32'(4 * i));
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_redirect_flush();
        bit found;
        lat_min = 3; lat_max = 3; key = 32'hCAFE_0000;
        do_reset();
        bus.if_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h0000_0100;
        tick();
        bus.redirect_valid = 1'b0;
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0 || bus.if_valid !== 1'b0)
            $display("FAIL flush_hold: req=%b addr=%h valid=%b, want 1 00000000 0", bus.mem_req, bus.mem_addr, bus.if_valid);
        else n_pass++;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.if_valid === 1'b1) found = 1'b1;
            else tick();
        end
        n_checks++;
        if (!found || bus.if_pc !== 32'h0000_0100 || bus.if_instr !== (32'h0000_0100 ^ key))
            $display("FAIL flush_target: seen=%b pc=%h instr=%h, want 1 00000100 %h", found, bus.if_pc, bus.if_instr, 32'h0000_0100 ^ key);
        else n_pass++;
        repeat (8) tick();
    endtask

    task automatic test_redirect_ack_pop();
        lat_min = 0; lat_max = 0; key = 32'h0F0F_0000;
        do_reset();
        bus.if_ready = 1'b1;
        rst_n = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h4 || bus.mem_req !== 1'b1)
            $display("FAIL rap_pre: valid=%b pc=%h req=%b, want 1 00000004 1", bus.if_valid, bus.if_pc, bus.mem_req);
        else n_pass++;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h0000_0203;
        tick();
        bus.redirect_valid = 1'b0;
        n_checks++;
        if (bus.if_valid !== 1'b0 || bus.misalign !== 1'b1 || bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_0200)
            $display("FAIL rap_after: valid=%b mis=%b req=%b addr=%h, want 0 1 1 00000200",
                     bus.if_valid, bus.misalign, bus.mem_req, bus.mem_addr);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0000_0200 || bus.if_instr !== (32'h0000_0200 ^ key) || bus.misalign !== 1'b0)
            $display("FAIL rap_target: valid=%b pc=%h instr=%h mis=%b, want 1 00000200 %h 0",
                     bus.if_valid, bus.if_pc, bus.if_instr, bus.misalign, 32'h0000_0200 ^ key);
        else n_pass++;
    endtask

    task automatic test_wrap();
        lat_min = 0; lat_max = 0; key = 32'h0000_0000;
        do_reset();
        bus.if_ready = 1'b1;
        rst_n = 1'b1;
        repeat (3) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        n_checks++;
        if (bus.mem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_req: addr=%h, want fffffffc", bus.mem_addr);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'hFFFF_FFFC || bus.mem_addr !== 32'h0)
            $display("FAIL wrap_next: valid=%b pc=%h addr=%h, want 1 fffffffc 00000000", bus.if_valid, bus.if_pc, bus.mem_addr);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0)
            $display("FAIL wrap_pc: valid=%b pc=%h, want 1 00000000", bus.if_valid, bus.if_pc);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit found;
        lat_min = 5; lat_max = 5; key = 32'h5A5A_5A5A;
        do_reset();
        rst_n = 1'b1;
        repeat (8) tick();
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.if_valid !== 1'b1)
            $display("FAIL rm_pre: req=%b valid=%b, want 1 1", bus.mem_req, bus.if_valid);
        else n_pass++;
        rst_n = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 32'h0000_0013;
        tick();
        bus.redirect_valid = 1'b0;
        n_checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_addr !== TB_RESET_PC || bus.if_valid !== 1'b0 ||
            bus.if_instr !== 32'h0 || bus.if_pc !== 32'h0 || bus.misalign !== 1'b0)
            $display("FAIL rm_reset: req=%b addr=%h valid=%b instr=%h pc=%h mis=%b, want all reset values",
                     bus.mem_req, bus.mem_addr, bus.if_valid, bus.if_instr, bus.if_pc, bus.misalign);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== TB_RESET_PC || bus.if_valid !== 1'b0)
            $display("FAIL rm_restart: req=%b addr=%h valid=%b, want 1 %h 0", bus.mem_req, bus.mem_addr, bus.if_valid, TB_RESET_PC);
        else n_pass++;
        bus.if_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.if_valid === 1'b1) found = 1'b1;
            else tick();
        end
        n_checks++;
        if (!found || bus.if_pc !== TB_RESET_PC)
            $display("FAIL rm_first: seen=%b pc=%h, want 1 %h", found, bus.if_pc, TB_RESET_PC);
        else n_pass++;
    endtask

    task automatic test_random();
        int pops_start;
        lat_min = 0; lat_max = 3; key = $urandom();
        do_reset();
        rst_n = 1'b1;
        pops_start = n_pops;
        for (int i = 0; i < 2000; i++) begin
            bus.if_ready       = ($urandom_range(0, 9) < 32'd7);
            bus.redirect_valid = ($urandom_range(0, 24) == 32'd0);
            if ($urandom_range(0, 3) == 32'd0) bus.redirect_addr = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            else bus.redirect_addr = $urandom();
            tick();
        end
        bus.redirect_valid = 1'b0;
        n_checks++;
        if (n_pops - pops_start < 150)
            $display("FAIL rand_progress: pops=%0d, want at least 150", n_pops - pops_start);
        else n_pass++;
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 32'h0000_0000;
        bus.mem_ack        = 1'b0;
        bus.mem_rdata      = 32'h0000_0000;
        bus.if_ready       = 1'b0;
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_redirect_flush();
        test_redirect_ack_pop();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
